lsu_mem_ctrl_way0: RTL and testbench
====================================

Name: lsu_mem_ctrl_way0

Overview:
- Way0 memory-access controller, directly downstream of the way0 FU register stage.
- Consumes its read/write address, write data, write mask and funct3, and runs a valid/ready bus transaction to data RAM.
- Returns dataOk (read complete, with the formatted load value) and writeState (write progress, 3'b111 = done); these feed back into the FU register's ready logic.

Parameters:
ADDR_W, 32, address width
DATA_W, 64, data bus width
MASK_W, 4, write mask width; forwarded unchanged to the bus

Ports:
clk  in  1  clock
reset_n  in  1  async active-low reset
req_valid_i  in  1  one-cycle pulse: new memory op present on inputs
readAddr_i  in  ADDR_W  load address; nonzero = load request
writeAddr_i  in  ADDR_W  store address; nonzero = store request
writeData_i  in  DATA_W  store data
writeMask_i  in  MASK_W  store mask
funct3_i  in  3  load type
mem_arvalid_o  out  1  read-address valid
mem_araddr_o  out  ADDR_W  read address
mem_arready_i  in  1  read-address accepted
mem_rvalid_i  in  1  read data valid
mem_rdata_i  in  DATA_W  read data, 8-byte-aligned lane
mem_rready_o  out  1  read data ready
mem_awvalid_o  out  1  write-address valid
mem_awaddr_o  out  ADDR_W  write address
mem_awready_i  in  1  write-address accepted
mem_wvalid_o  out  1  write-data valid
mem_wdata_o  out  DATA_W  write data
mem_wmask_o  out  MASK_W  write mask
mem_wready_i  in  1  write data accepted
mem_bvalid_i  in  1  write response valid
mem_bready_o  out  1  write response ready
dataOk_o  out  1  one-cycle pulse: load complete
rdData_o  out  DATA_W  formatted load result
writeState_o  out  3  store progress: [0] aw done, [1] w done, [2] b done

Behaviour:
- Reset: state IDLE; all outputs 0, including latched addr/data/mask/funct3. Assertion mid-transaction abandons it immediately; bus valids drop asynchronously.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.
- IDLE, req_valid_i=1:
  - readAddr_i != 0 -> latch addr and funct3, go RD_ADDR.
  - else writeAddr_i != 0 -> latch addr/data/mask, go WR_REQ.
  - Both nonzero: read wins; store dropped.
  - Both zero, or req_valid_i=0: stay IDLE.
- Inputs are ignored outside IDLE.
- Requests accepted in IDLE are not taken on the completion cycle; earliest re-accept is the cycle after dataOk_o or writeState_o = 3'b111.
- RD_ADDR:
  - mem_arvalid_o = 1, address held stable until mem_arready_i.
  - Handshake -> RD_DATA.
- RD_DATA:
  - mem_rready_o = 1.
  - On mem_rvalid_i: register rdData_o, pulse dataOk_o for exactly one cycle (registered, so 1 cycle after the handshake edge), go IDLE.
- Read latency: minimum 3 cycles from req_valid_i to dataOk_o, with zero-wait-state memory.
- Load format:
  - Shift mem_rdata_i right by addr[2:0]*8.
  - funct3 000 LB sign-extend 8, 001 LH sign-extend 16, 010 LW sign-extend 32, 011 LD full 64.
  - funct3 100 LBU, 101 LHU, 110 LWU zero-extend.
  - funct3 111 -> 0.
  - Misaligned accesses are not split; shifted-in upper bytes are zero before extension.
- rdData_o holds its value until the next load completes.
- WR_REQ:
  - mem_awvalid_o and mem_wvalid_o asserted concurrently.
  - Each drops independently after its own handshake; writeState_o[0] / [1] set on the respective handshake. Order is arbitrary; simultaneous is allowed.
  - When both are set -> WR_RESP.
- WR_RESP:
  - mem_bready_o = 1.
  - On mem_bvalid_i: writeState_o = 3'b111 for exactly one cycle, then 3'b000 in IDLE.
- writeState_o never reads 3'b111 except on that completion cycle.
- dataOk_o and writeState_o = 3'b111 are never asserted in the same cycle.
- Bus valids: once asserted they never drop before their handshake, except on reset.

Decomposition:
- Shared package holds:
  - the state enum (mem_state_t);
  - funct3 load encodings (LB..LWU);
  - the WR_DONE = 3'b111 constant.
- One sub-module is natural: load_align (combinational shift + extend on rdata, addr[2:0], funct3), reusable by way1.

Test Plan:
- LD at 0x8000_0010, arready and rvalid both immediate, rdata 0x1122334455667788 -> dataOk_o pulses 3 cycles after req, rdData_o = 0x1122334455667788.
- LB at 0x8000_0013 (offset 3), rdata 0x0000_0000_F000_0000 -> rdData_o = 0xFFFF_FFFF_FFFF_FFF0; same with LBU -> 0xF0.
- Store to 0x8000_0020 with data 0xDEADBEEF and mask 4'b0011; wready arrives 2 cycles after awready, bvalid 3 cycles after that -> writeState_o reads 001, then 011, then 111 for exactly one cycle, then 000; mem_wdata_o/mem_wmask_o stay stable while wvalid is high.
- req_valid_i with both readAddr and writeAddr nonzero -> only an AR transaction occurs, no AW/W; a second req_valid_i pulse during RD_DATA is ignored.
- reset_n low during WR_REQ (aw done, w pending) -> all valids 0 and writeState_o = 000 immediately; after release, a new LW completes normally.
- arready held low for 10 cycles -> mem_arvalid_o and mem_araddr_o stay stable throughout and dataOk_o stays 0.

Source files
------------

// File: rtl/lsu_mem_ctrl_way0_pkg.sv
// rtl/lsu_mem_ctrl_way0_pkg.sv - shared types and constants for the way0 memory-access controller
package lsu_mem_ctrl_way0_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ADDR = 3'd1,
    S_RD_DATA = 3'd2,
    S_WR_REQ  = 3'd3,
    S_WR_RESP = 3'd4
  } mem_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  localparam logic [2:0] WR_DONE = 3'b111;

endpackage

// File: rtl/lsu_mem_ctrl_way0_load_align.sv
// rtl/lsu_mem_ctrl_way0_load_align.sv - shifts an 8-byte read lane by the address offset and extends per funct3
module lsu_mem_ctrl_way0_load_align
  import lsu_mem_ctrl_way0_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [2:0]        offset_i,
  input  logic [2:0]        funct3_i,
  output logic [DATA_W-1:0] data_o
);

  logic [DATA_W-1:0] shifted;

  // Bytes shifted in from above the lane are zero; extension is applied afterwards.
  assign shifted = rdata_i >> {offset_i, 3'b000};

  always_comb begin
    data_o = '0;
    case (funct3_i)
      F3_LB:   data_o = {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
      F3_LH:   data_o = {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
      F3_LW:   data_o = {{(DATA_W-32){shifted[31]}}, shifted[31:0]};
      F3_LD:   data_o = shifted;
      F3_LBU:  data_o = {{(DATA_W-8){1'b0}}, shifted[7:0]};
      F3_LHU:  data_o = {{(DATA_W-16){1'b0}}, shifted[15:0]};
      F3_LWU:  data_o = {{(DATA_W-32){1'b0}}, shifted[31:0]};
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl_way0.sv
// rtl/lsu_mem_ctrl_way0.sv - way0 load/store bus controller driving valid/ready data RAM transactions
module lsu_mem_ctrl_way0
  import lsu_mem_ctrl_way0_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int MASK_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid_i,
  input  logic [ADDR_W-1:0] readAddr_i,
  input  logic [ADDR_W-1:0] writeAddr_i,
  input  logic [DATA_W-1:0] writeData_i,
  input  logic [MASK_W-1:0] writeMask_i,
  input  logic [2:0]        funct3_i,
  output logic              mem_arvalid_o,
  output logic [ADDR_W-1:0] mem_araddr_o,
  input  logic              mem_arready_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              mem_rready_o,
  output logic              mem_awvalid_o,
  output logic [ADDR_W-1:0] mem_awaddr_o,
  input  logic              mem_awready_i,
  output logic              mem_wvalid_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [MASK_W-1:0] mem_wmask_o,
  input  logic              mem_wready_i,
  input  logic              mem_bvalid_i,
  output logic              mem_bready_o,
  output logic              dataOk_o,
  output logic [DATA_W-1:0] rdData_o,
  output logic [2:0]        writeState_o
);

  mem_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [MASK_W-1:0] wmask_q, wmask_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [2:0]        wr_state_q, wr_state_d;
  logic              data_ok_q, data_ok_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [DATA_W-1:0] load_data;
  logic              can_accept;

  lsu_mem_ctrl_way0_load_align #(.DATA_W(DATA_W)) u_load_align (
    .rdata_i  (mem_rdata_i),
    .offset_i (addr_q[2:0]),
    .funct3_i (funct3_q),
    .data_o   (load_data)
  );

  // The completion cycle still sits in IDLE but must not take a new request.
  assign can_accept = req_valid_i && !data_ok_q && (wr_state_q != WR_DONE);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    funct3_d   = funct3_q;
    wr_state_d = wr_state_q;
    data_ok_d  = 1'b0;
    rd_data_d  = rd_data_q;
    case (state_q)
      S_IDLE: begin
        wr_state_d = 3'b000;
        if (can_accept) begin
          if (readAddr_i != '0) begin
            addr_d   = readAddr_i;
            funct3_d = funct3_i;
            state_d  = S_RD_ADDR;
          end else if (writeAddr_i != '0) begin
            addr_d  = writeAddr_i;
            wdata_d = writeData_i;
            wmask_d = writeMask_i;
            state_d = S_WR_REQ;
          end
        end
      end
      S_RD_ADDR: begin
        if (mem_arready_i) state_d = S_RD_DATA;
      end
      S_RD_DATA: begin
        if (mem_rvalid_i) begin
          rd_data_d = load_data;
          data_ok_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_WR_REQ: begin
        // AW and W complete independently; a ready seen after its own handshake is harmless.
        wr_state_d[0] = wr_state_q[0] | mem_awready_i;
        wr_state_d[1] = wr_state_q[1] | mem_wready_i;
        if (wr_state_d[0] && wr_state_d[1]) state_d = S_WR_RESP;
      end
      S_WR_RESP: begin
        if (mem_bvalid_i) begin
          wr_state_d = WR_DONE;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      funct3_q   <= '0;
      wr_state_q <= '0;
      data_ok_q  <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wmask_q    <= wmask_d;
      funct3_q   <= funct3_d;
      wr_state_q <= wr_state_d;
      data_ok_q  <= data_ok_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign mem_arvalid_o = (state_q == S_RD_ADDR);
  assign mem_araddr_o  = addr_q;
  assign mem_rready_o  = (state_q == S_RD_DATA);
  assign mem_awvalid_o = (state_q == S_WR_REQ) && !wr_state_q[0];
  assign mem_awaddr_o  = addr_q;
  assign mem_wvalid_o  = (state_q == S_WR_REQ) && !wr_state_q[1];
  assign mem_wdata_o   = wdata_q;
  assign mem_wmask_o   = wmask_q;
  assign mem_bready_o  = (state_q == S_WR_RESP);
  assign dataOk_o      = data_ok_q;
  assign rdData_o      = rd_data_q;
  assign writeState_o  = wr_state_q;

endmodule

// File: tb/tb_lsu_mem_ctrl_way0.sv
// tb/tb_lsu_mem_ctrl_way0.sv - self-checking bench for lsu_mem_ctrl_way0
module tb_lsu_mem_ctrl_way0;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic [31:0] readAddr, writeAddr;
  logic [63:0] writeData;
  logic [3:0]  writeMask;
  logic [2:0]  funct3;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] araddr, awaddr;
  logic [63:0] rdata, wdata, rdData;
  logic        awvalid, awready, wvalid, wready, bvalid, bready, dataOk;
  logic [3:0]  wmask;
  logic [2:0]  writeState;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lsu_mem_ctrl_way0 dut (
    .clk(clk), .reset_n(reset_n), .req_valid_i(req_valid),
    .readAddr_i(readAddr), .writeAddr_i(writeAddr), .writeData_i(writeData),
    .writeMask_i(writeMask), .funct3_i(funct3),
    .mem_arvalid_o(arvalid), .mem_araddr_o(araddr), .mem_arready_i(arready),
    .mem_rvalid_i(rvalid), .mem_rdata_i(rdata), .mem_rready_o(rready),
    .mem_awvalid_o(awvalid), .mem_awaddr_o(awaddr), .mem_awready_i(awready),
    .mem_wvalid_o(wvalid), .mem_wdata_o(wdata), .mem_wmask_o(wmask),
    .mem_wready_i(wready), .mem_bvalid_i(bvalid), .mem_bready_o(bready),
    .dataOk_o(dataOk), .rdData_o(rdData), .writeState_o(writeState)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference load formatter: pick bytes from offset upward, then extend by access size.
  function automatic logic [63:0] load_ref(input logic [63:0] d, input logic [2:0] off,
                                           input logic [2:0] f3);
    logic [7:0]  b [8];
    logic [63:0] v;
    int n, idx;
    for (int i = 0; i < 8; i++) begin
      idx = i + int'(off);
      b[i] = 8'h00;
      if (idx < 8) b[i] = d[8*idx +: 8];
    end
    if (f3 == 3'b111) return 64'h0;
    n = 1 << f3[1:0];
    v = 64'h0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = b[i];
    if (!f3[2] && n < 8 && b[n-1][7])
      for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  task automatic run_load(input logic [31:0] addr, input logic [2:0] f3, input logic [63:0] data,
                          input int ar_wait, input int r_wait, input bit both, input bit spam);
    logic [63:0] exp;
    exp = load_ref(data, addr[2:0], f3);
    req_valid = 1'b1; readAddr = addr; funct3 = f3;
    writeAddr = both ? 32'h9000_0040 : 32'h0;
    writeData = {$urandom, $urandom}; writeMask = 4'($urandom);
    arready = 1'b0; rvalid = 1'b0;
    tick();
    req_valid = 1'b0; readAddr = $urandom | 32'h1; funct3 = 3'($urandom);
    for (int i = 0; i < ar_wait; i++) begin
      check("ar_wait_arvalid", 64'(arvalid), 64'd1);
      check("ar_wait_araddr", 64'(araddr), 64'(addr));
      check("ar_wait_dataok", 64'(dataOk), 64'd0);
      check("ar_wait_awvalid", 64'(awvalid | wvalid), 64'd0);
      req_valid = spam;
      tick();
      req_valid = 1'b0;
    end
    check("ar_arvalid", 64'(arvalid), 64'd1);
    check("ar_araddr", 64'(araddr), 64'(addr));
    arready = 1'b1;
    tick();
    arready = 1'b0;
    for (int i = 0; i < r_wait; i++) begin
      check("r_wait_rready", 64'(rready), 64'd1);
      check("r_wait_arvalid", 64'(arvalid), 64'd0);
      check("r_wait_dataok", 64'(dataOk), 64'd0);
      req_valid = spam;
      tick();
      req_valid = 1'b0;
    end
    check("r_rready", 64'(rready), 64'd1);
    check("r_no_aw", 64'(awvalid | wvalid), 64'd0);
    rvalid = 1'b1; rdata = data;
    tick();
    rvalid = 1'b0; rdata = {$urandom, $urandom};
    check("load_dataok", 64'(dataOk), 64'd1);
    check("load_rddata", rdData, exp);
    check("load_wstate", 64'(writeState), 64'd0);
    req_valid = 1'b1; readAddr = addr | 32'h1;
    tick();
    req_valid = 1'b0; readAddr = 32'h0;
    check("load_dataok_pulse", 64'(dataOk), 64'd0);
    check("load_no_reaccept", 64'(arvalid), 64'd0);
    check("load_rddata_hold", rdData, exp);
  endtask

  task automatic run_store(input logic [31:0] addr, input logic [63:0] data, input logic [3:0] mask,
                           input int aw_wait, input int w_wait, input int b_wait);
    bit aw_d, w_d;
    int c;
    req_valid = 1'b1; writeAddr = addr; readAddr = 32'h0; writeData = data; writeMask = mask;
    tick();
    req_valid = 1'b0; writeAddr = $urandom; writeData = ~data; writeMask = ~mask;
    aw_d = 1'b0; w_d = 1'b0; c = 0;
    while (!(aw_d && w_d) && c < 50) begin
      check("wr_awvalid", 64'(awvalid), 64'(!aw_d));
      check("wr_wvalid", 64'(wvalid), 64'(!w_d));
      check("wr_awaddr", 64'(awaddr), 64'(addr));
      check("wr_wdata", wdata, data);
      check("wr_wmask", 64'(wmask), 64'(mask));
      check("wr_state", 64'(writeState), {61'd0, 1'b0, w_d, aw_d});
      check("wr_no_ar", 64'(arvalid), 64'd0);
      awready = (c >= aw_wait);
      wready  = (c >= w_wait);
      tick();
      if (awready) aw_d = 1'b1;
      if (wready) w_d = 1'b1;
      c++;
    end
    check("wr_budget", 64'(c < 50), 64'd1);
    awready = 1'b0; wready = 1'b0;
    for (int i = 0; i < b_wait; i++) begin
      check("b_wait_bready", 64'(bready), 64'd1);
      check("b_wait_wstate", 64'(writeState), 64'd3);
      check("b_wait_valids", 64'(awvalid | wvalid), 64'd0);
      tick();
    end
    check("b_bready", 64'(bready), 64'd1);
    bvalid = 1'b1;
    tick();
    bvalid = 1'b0;
    check("wr_done_state", 64'(writeState), 64'd7);
    check("wr_done_dataok", 64'(dataOk), 64'd0);
    check("wr_done_bready", 64'(bready), 64'd0);
    req_valid = 1'b1; writeAddr = addr;
    tick();
    req_valid = 1'b0; writeAddr = 32'h0;
    check("wr_state_clear", 64'(writeState), 64'd0);
    check("wr_no_reaccept", 64'(awvalid), 64'd0);
  endtask

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; readAddr = '0; writeAddr = '0; writeData = '0;
    writeMask = '0; funct3 = '0; arready = 1'b0; rvalid = 1'b0; rdata = '0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    tick(); tick();
    check("rst_arvalid", 64'(arvalid), 64'd0);
    check("rst_valids", 64'({awvalid, wvalid, rready, bready}), 64'd0);
    check("rst_dataok", 64'(dataOk), 64'd0);
    check("rst_rddata", rdData, 64'd0);
    check("rst_wstate", 64'(writeState), 64'd0);
    check("rst_addr", 64'({araddr, awaddr}), 64'd0);
    check("rst_wdata", wdata, 64'd0);
    check("rst_wmask", 64'(wmask), 64'd0);
    reset_n = 1'b1;
    tick();

    run_load(32'h8000_0010, 3'b011, 64'h1122334455667788, 0, 0, 0, 0);
    run_load(32'h8000_0013, 3'b000, 64'h0000_0000_F000_0000, 0, 0, 0, 0);
    run_load(32'h8000_0013, 3'b100, 64'h0000_0000_F000_0000, 0, 0, 0, 0);
    run_store(32'h8000_0020, 64'hDEADBEEF, 4'b0011, 0, 2, 3);
    run_load(32'h8000_0046, 3'b010, 64'h8765_4321_0FED_CBA9, 1, 2, 1, 1);
    run_load(32'h8000_0008, 3'b111, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 0);
    run_load(32'h8000_0100, 3'b001, 64'h0000_0000_0000_8001, 10, 0, 0, 0);

    // Reset with AW done and W still pending.
    req_valid = 1'b1; writeAddr = 32'h8000_0080; readAddr = '0;
    writeData = 64'h0123_4567_89AB_CDEF; writeMask = 4'hF;
    tick();
    req_valid = 1'b0; awready = 1'b1;
    tick();
    awready = 1'b0;
    check("mid_wstate", 64'(writeState), 64'd1);
    check("mid_wvalid", 64'(wvalid), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_valids", 64'({arvalid, awvalid, wvalid, bready, rready}), 64'd0);
    check("async_rst_wstate", 64'(writeState), 64'd0);
    check("async_rst_wdata", wdata, 64'd0);
    tick();
    reset_n = 1'b1;
    tick();
    run_load(32'h8000_0204, 3'b010, 64'h8000_0001_0000_0000, 0, 1, 0, 0);

    for (int k = 0; k < 20; k++)
      run_load($urandom | 32'h8000_0000, 3'($urandom), {$urandom, $urandom},
               $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'($urandom));
    for (int k = 0; k < 8; k++)
      run_store($urandom | 32'h8000_0000, {$urandom, $urandom}, 4'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
